// File: rtl/sar_pkg.sv
// Shared types for the SAR result-capture stage: default resolution,
// capture FSM states and the captured result record.
package sar_pkg;

  localparam int DEF_NBITS = 10;
  localparam int DEF_CNTW  = 16;
  localparam int DEF_NW    = $clog2(DEF_NBITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } sar_state_t;

  typedef struct packed {
    logic [DEF_NBITS-1:0] code;
    logic [DEF_NW-1:0]    ndone;
    logic                 incomplete;
    logic                 bubble;
  } sar_result_t;

endpackage

// File: rtl/therm_decode.sv
// Thermometer progress decoder: count of completed trials (lowest zero bit)
// and a flag for any set bit above that zero.
module therm_decode #(
  parameter int NBITS = 10
) (
  input  logic [NBITS-1:0]             clc,
  output logic [$clog2(NBITS+1)-1:0]   ndone,
  output logic                         bubble
);

  localparam int NW = $clog2(NBITS + 1);

  logic found;

  always_comb begin
    ndone  = NW'(NBITS);
    bubble = 1'b0;
    found  = 1'b0;
    for (int k = 0; k < NBITS; k++) begin
      if (!found && !clc[k]) begin
        ndone = NW'(k);
        found = 1'b1;
      end else if (found && clc[k]) begin
        bubble = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_result.sv
// SAR result capture: two-flop synchronizer, thermometer decode, prime/run FSM
// and valid/ready output register. Optional error counter: SAR_RESULT_ERRCNT_EN.
module sar_result
  import sar_pkg::*;
#(
  parameter int NBITS = DEF_NBITS
`ifdef SAR_RESULT_ERRCNT_EN
  , parameter int CNTW = DEF_CNTW
`endif
) (
  input  logic                       clock,
  input  logic                       resn,
  input  logic                       en,
  input  logic [NBITS-1:0]           clc,
  input  logic [NBITS-1:0]           dec,
  output logic [NBITS-1:0]           code,
  output logic                       code_valid,
  input  logic                       code_ready,
  output logic [$clog2(NBITS+1)-1:0] ndone,
  output logic                       incomplete,
  output logic                       bubble,
  output logic                       overflow
`ifdef SAR_RESULT_ERRCNT_EN
  , input  logic                     err_clr,
  output logic [CNTW-1:0]            err_cnt
`endif
);

  localparam int NW = $clog2(NBITS + 1);

  typedef struct packed {
    logic [NBITS-1:0] code;
    logic [NW-1:0]    ndone;
    logic             incomplete;
    logic             bubble;
  } result_t;

  logic [NBITS-1:0] s1_clc, s1_dec, s2_clc, s2_dec;
  logic [NW-1:0]    d_ndone;
  logic             d_bubble;
  logic [NBITS-1:0] d_code;
  result_t          d_res, res;
  sar_state_t       state;
  logic             prime_cnt;
  logic             load_slot, load;

  // Stage s1/s2: synchronizer, free-running regardless of en
  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      s1_clc <= '0;
      s1_dec <= '0;
      s2_clc <= '0;
      s2_dec <= '0;
    end else begin
      s1_clc <= clc;
      s1_dec <= dec;
      s2_clc <= s1_clc;
      s2_dec <= s1_dec;
    end
  end

  therm_decode #(.NBITS(NBITS)) u_decode (
    .clc    (s2_clc),
    .ndone  (d_ndone),
    .bubble (d_bubble)
  );

  // Decisions arrive MSB-first; unresolved trials read as 0
  always_comb begin
    d_code = '0;
    for (int k = 0; k < NBITS; k++) begin
      if (k < int'(d_ndone)) d_code[NBITS-1-k] = s2_dec[k];
    end
  end

  assign d_res = '{code:       d_code,
                   ndone:      d_ndone,
                   incomplete: (int'(d_ndone) < NBITS),
                   bubble:     d_bubble};

  // PRIME holds two edges so pre-enable synchronizer contents never load
  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      state     <= IDLE;
      prime_cnt <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          state     <= PRIME;
          prime_cnt <= 1'b0;
        end
        PRIME: begin
          if (prime_cnt) state <= RUN;
          else           prime_cnt <= 1'b1;
        end
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  assign load_slot = (state == RUN) && en;
  assign load      = load_slot && (!code_valid || code_ready);

  // Stage out: held result register with valid/ready handshake
  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      res        <= '0;
      code_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= load_slot && !load;
      if (load) begin
        res        <= d_res;
        code_valid <= 1'b1;
      end else if (code_ready) begin
        code_valid <= 1'b0;
      end
    end
  end

  assign code       = res.code;
  assign ndone      = res.ndone;
  assign incomplete = res.incomplete;
  assign bubble     = res.bubble;

`ifdef SAR_RESULT_ERRCNT_EN
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (load && (d_res.incomplete || d_res.bubble)) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end
`endif

endmodule
